// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin arbiter sharing one synchronous single-port SRAM
// among NUM_REQ requesters, with an optional ownership lock for multi-beat sequences.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   req_valid/req_ready per-requester request / one-hot grant (beat fires on valid & ready)
//   req_we, req_lock    per-requester write flag and keep-ownership flag
//   req_addr, req_wdata packed per-requester address / write data
//   rsp_valid           one-hot read response valid, one cycle after the read beat
//   rsp_rdata           shared read data (SRAM data_out passthrough)
//   mem_*               SRAM address, write data, write enable and read data
//
// Optional: define SRAM_ARB_STATS_EN to add stats_clr / stats_cnt, a saturating
// 32-bit grant counter per requester.
module sram_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
`ifdef SRAM_ARB_STATS_EN
    input  logic                           stats_clr,
    output logic [NUM_REQ*32-1:0]          stats_cnt,
`endif
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ-1:0]             req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [DATA_WIDTH-1:0]          mem_data_in,
    output logic                           mem_we,
    input  logic [DATA_WIDTH-1:0]          mem_data_out
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr, owner, g, idx, nxt;
    logic [IW:0]     sum;
    logic            found, fire;
    logic [ADDR_WIDTH-1:0] addr_a  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_a[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_a[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Descending scan so the lowest offset from rr_ptr is the last (winning) hit.
    always_comb begin
        found = 1'b0;
        g     = '0;
        sum   = '0;
        idx   = '0;
        if (state == LOCKED) begin
            found = req_valid[owner];
            g     = owner;
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                sum = {1'b0, rr_ptr} + (IW+1)'(k);
                idx = IW'(sum >= (IW+1)'(NUM_REQ) ? sum - (IW+1)'(NUM_REQ) : sum);
                if (req_valid[idx]) begin
                    found = 1'b1;
                    g     = idx;
                end
            end
        end
    end

    // Holding rst low blocks every grant, so nothing reaches the SRAM during reset.
    assign fire        = found & rst;
    assign req_ready   = fire ? NUM_REQ'(1) << g : '0;
    assign mem_addr    = fire ? addr_a[g] : '0;
    assign mem_data_in = fire ? wdata_a[g] : '0;
    assign mem_we      = fire & req_we[g];
    assign rsp_rdata   = mem_data_out;
    assign nxt         = (g == IW'(NUM_REQ - 1)) ? '0 : g + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            rsp_valid <= '0;
        end else begin
            rsp_valid <= (fire && !req_we[g]) ? req_ready : '0;
            if (fire) begin
                rr_ptr <= nxt;
                if (state == IDLE) begin
                    if (req_lock[g]) begin
                        state <= LOCKED;
                        owner <= g;
                    end
                end else if (!req_lock[g]) begin
                    state <= IDLE;
                end
            end
        end
    end

`ifdef SRAM_ARB_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        logic [31:0] cnt;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                cnt <= '0;
            else if (stats_clr)
                cnt <= '0;
            else if (req_ready[i] && cnt != '1)
                cnt <= cnt + 32'd1;
        end
        assign stats_cnt[i*32 +: 32] = cnt;
    end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed bench for sram_port_arbiter with a behavioural SRAM.
module tb_sram_port_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid, req_ready, req_we, req_lock, rsp_valid;
    logic [63:0]  req_addr;
    logic [127:0] req_wdata;
    logic [31:0]  rsp_rdata, mem_data_in, mem_dout;
    logic [15:0]  mem_addr;
    logic         mem_we;
    logic [31:0]  mem [0:65535];
`ifdef SRAM_ARB_STATS_EN
    logic         stats_clr;
    logic [127:0] stats_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_data_in;
        mem_dout <= mem[mem_addr];
    end

    sram_port_arbiter dut (
`ifdef SRAM_ARB_STATS_EN
        .stats_clr(stats_clr),
        .stats_cnt(stats_cnt),
`endif
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_lock(req_lock),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .mem_addr(mem_addr),
        .mem_data_in(mem_data_in),
        .mem_we(mem_we),
        .mem_data_out(mem_dout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; checks run 1 time unit later,
    // well before the next rising edge.
    task automatic cyc(input logic [3:0] v, input logic [3:0] we, input logic [3:0] lk);
        @(negedge clk);
        req_valid = v;
        req_we    = we;
        req_lock  = lk;
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 4'hF;
        req_we    = 4'hF;
        req_lock  = 4'h0;
        req_addr  = '0;
        req_wdata = '0;
`ifdef SRAM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        for (int i = 0; i < 3; i++) begin
            cyc(4'hF, 4'hF, 4'h0);
            chk("reset_ready", req_ready, 4'b0000);
            chk("reset_we", mem_we, 1'b0);
            chk("reset_rsp", rsp_valid, 4'b0000);
        end

        // Release reset and stream reads from all four requesters.
        @(negedge clk);
        rst = 1'b1;
        req_we = 4'h0;
        for (int i = 0; i < 4; i++) req_addr[i*16 +: 16] = 16'h0100 + 16'(i);
        #1;
        chk("fair_g0", req_ready, 4'b0001);
        chk("fair_addr0", mem_addr, 16'h0100);
        cyc(4'hF, 4'h0, 4'h0); chk("fair_g1", req_ready, 4'b0010); chk("fair_r0", rsp_valid, 4'b0001);
        cyc(4'hF, 4'h0, 4'h0); chk("fair_g2", req_ready, 4'b0100); chk("fair_r1", rsp_valid, 4'b0010);
        cyc(4'hF, 4'h0, 4'h0); chk("fair_g3", req_ready, 4'b1000); chk("fair_r2", rsp_valid, 4'b0100);
        chk("fair_addr3", mem_addr, 16'h0103);
        cyc(4'hF, 4'h0, 4'h0); chk("fair_g0b", req_ready, 4'b0001); chk("fair_r3", rsp_valid, 4'b1000);
        cyc(4'hF, 4'h0, 4'h0); chk("fair_g1b", req_ready, 4'b0010); chk("fair_r0b", rsp_valid, 4'b0001);

        // req1 writes, req2 reads the same address next cycle.
        req_addr[16 +: 16] = 16'h1234;
        req_wdata[32 +: 32] = 32'hDEADBEEF;
        req_addr[32 +: 16] = 16'h1234;
        cyc(4'b0010, 4'b0010, 4'h0);
        chk("wr_ready", req_ready, 4'b0010);
        chk("wr_we", mem_we, 1'b1);
        chk("wr_addr", mem_addr, 16'h1234);
        chk("wr_data", mem_data_in, 32'hDEADBEEF);
        chk("wr_rsp_prev", rsp_valid, 4'b0010);
        cyc(4'b0100, 4'b0010, 4'h0);
        chk("rd_ready", req_ready, 4'b0100);
        chk("rd_we", mem_we, 1'b0);
        chk("rd_addr", mem_addr, 16'h1234);
        chk("wr_no_rsp", rsp_valid, 4'b0000);
        cyc(4'h0, 4'h0, 4'h0);
        chk("idle_ready", req_ready, 4'b0000);
        chk("idle_addr", mem_addr, 16'h0000);
        chk("idle_data", mem_data_in, 32'h0);
        chk("raw_rsp", rsp_valid, 4'b0100);
        chk("raw_data", rsp_rdata, 32'hDEADBEEF);

        // req0 reads 0x1234, then req3 overwrites it: the read sees old data.
        req_addr[0 +: 16] = 16'h1234;
        req_addr[48 +: 16] = 16'h1234;
        req_wdata[96 +: 32] = 32'hCAFEF00D;
        cyc(4'b0001, 4'h0, 4'h0);
        chk("war_rd", req_ready, 4'b0001);
        cyc(4'b1000, 4'b1000, 4'h0);
        chk("war_wr", req_ready, 4'b1000);
        chk("war_we", mem_we, 1'b1);
        chk("war_rsp", rsp_valid, 4'b0001);
        chk("war_old", rsp_rdata, 32'hDEADBEEF);
        cyc(4'b0001, 4'h0, 4'h0);
        chk("war_rd2", req_ready, 4'b0001);
        cyc(4'h0, 4'h0, 4'h0);
        chk("war_new", rsp_rdata, 32'hCAFEF00D);
        chk("war_rsp2", rsp_valid, 4'b0001);

        // Lock: rr_ptr is now 1, so first align it back to 0 with a req3 beat.
        cyc(4'b1000, 4'h0, 4'h0);
        chk("align", req_ready, 4'b1000);
        cyc(4'hF, 4'h0, 4'b1111);
        chk("lock_b1", req_ready, 4'b0001);
        cyc(4'b1110, 4'h0, 4'b1110);
        chk("lock_gap", req_ready, 4'b0000);
        chk("lock_gap_rsp", rsp_valid, 4'b0001);
        cyc(4'hF, 4'h0, 4'b1111);
        chk("lock_b2", req_ready, 4'b0001);
        chk("lock_b2_rsp0", rsp_valid, 4'b0000);
        cyc(4'hF, 4'h0, 4'b1110);
        chk("lock_b3", req_ready, 4'b0001);
        cyc(4'hF, 4'h0, 4'h0);
        chk("unlock_next", req_ready, 4'b0010);
        chk("unlock_rsp", rsp_valid, 4'b0001);

        // Mid-operation reset while req2 holds a lock and its read is pending.
        cyc(4'b0100, 4'h0, 4'b0100);
        chk("mid_g2", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = 4'hF;
        req_lock = 4'h0;
        chk("mid_pending", rsp_valid, 4'b0100);
        rst = 1'b0;
        #1;
        chk("mid_rsp_drop", rsp_valid, 4'b0000);
        chk("mid_ready0", req_ready, 4'b0000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_after", req_ready, 4'b0001);

`ifdef SRAM_ARB_STATS_EN
        chk("stats_reset", stats_cnt[96 +: 32], 32'd0);
        cyc(4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 5; i++) cyc(4'b1000, 4'h0, 4'h0);
        cyc(4'h0, 4'h0, 4'h0);
        chk("stats_cnt3", stats_cnt[96 +: 32], 32'd5);
        chk("stats_cnt0", stats_cnt[0 +: 32], 32'd1);
        stats_clr = 1'b1;
        cyc(4'b1000, 4'h0, 4'h0);
        chk("stats_clr_fire", req_ready, 4'b1000);
        @(negedge clk);
        stats_clr = 1'b0;
        req_valid = 4'h0;
        #1;
        chk("stats_cleared", stats_cnt[96 +: 32], 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one synchronous single-port SRAM among NUM_REQ requesters.
- SRAM characteristics: 32-bit data, 16-bit address, registered read with 1-cycle latency, write on we at posedge.
- Grants at most one access per cycle using round-robin priority, with an optional lock that holds ownership for multi-beat sequences.
- Returns read data one cycle after grant, with a one-hot tag to the requester that issued the read.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 16, SRAM address width
- DATA_WIDTH, 32, SRAM data width

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester access request
- req_ready  output  NUM_REQ  one-hot grant; a beat fires when req_valid[i] & req_ready[i]
- req_we  input  NUM_REQ  1 = write, 0 = read
- req_lock  input  NUM_REQ  keep ownership after this beat
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data
- rsp_valid  output  NUM_REQ  one-hot read-data valid
- rsp_rdata  output  DATA_WIDTH  read data, shared by all requesters
- mem_addr  output  ADDR_WIDTH  to SRAM addr
- mem_data_in  output  DATA_WIDTH  to SRAM data_in
- mem_we  output  1  to SRAM we
- mem_data_out  input  DATA_WIDTH  from SRAM data_out

Behaviour:
- Reset, asynchronous with rst low:
  - state = IDLE, rr_ptr = 0, owner = 0, rsp_valid = 0.
  - req_ready and mem_we are forced 0 while rst is low.
- Grant is combinational in the same cycle as the request.
  - IDLE: grant the first req_valid[i] searching i = rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - LOCKED: only owner can be granted; req_ready[owner] = req_valid[owner]. All other requesters see ready = 0.
  - No valid requester: req_ready = 0, mem_we = 0.
- SRAM drive:
  - mem_addr and mem_data_in are muxed from the granted requester.
  - mem_addr = 0 and mem_data_in = 0 when nothing is granted.
  - mem_we = fire & req_we[g].
- Round-robin pointer: on any fire by requester g, rr_ptr <= (g+1) mod NUM_REQ, in both IDLE and LOCKED.
- State machine (updates only on fire):
  - IDLE -> LOCKED when req_lock[g] = 1; owner <= g.
  - LOCKED -> LOCKED when owner fires with req_lock = 1.
  - LOCKED -> IDLE when owner fires with req_lock = 0. That beat is still performed.
  - In LOCKED, an owner with req_valid low keeps the lock; no timeout.
- Read response:
  - Read fire in cycle T gives rsp_valid = onehot(g) in cycle T+1; otherwise rsp_valid = 0 in T+1.
  - rsp_rdata = mem_data_out, combinational passthrough; only meaningful while rsp_valid != 0.
  - Back-to-back reads give one response per cycle, in order.
  - Writes produce no response.
- Same address, write in T then read in T+1: the read returns the new data.
- Same address, read in T then write in T+1: the read returns the old data.
- Reset asserted mid-operation: a pending response is discarded (rsp_valid = 0 immediately) and any lock is released.
- req_we, req_lock, req_addr and req_wdata are ignored for requesters that are not granted.

Optional Feature:
- Macro: SRAM_ARB_STATS_EN.
- Defined: adds ports stats_clr (input, 1) and stats_cnt (output, NUM_REQ*32).
  - Each requester has a 32-bit grant counter that increments on each of its fires and saturates at 0xFFFFFFFF.
  - stats_clr = 1 zeroes all counters on the next edge; clear wins over a simultaneous increment.
  - rst zeroes the counters.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle: rst = 0 for 3 cycles with all req_valid = 1 -> req_ready = 0, mem_we = 0, rsp_valid = 0; first cycle after release grants requester 0.
- Fairness: all four requesters issue continuous reads -> grants cycle 0,1,2,3,0,1; rsp_valid follows one cycle later as 0001, 0010, 0100, 1000.
- Write/read: req1 writes 0xDEADBEEF to 0x1234, then req2 reads 0x1234 the next cycle -> rsp_valid = 0100 with rsp_rdata = 0xDEADBEEF.
- Lock: req0 issues 3 beats with lock = 1,1,0 while req1..3 are valid.
  - Expected: req0 granted 3 consecutive beats even through a req_valid[0] gap cycle.
  - Expected: the beat after unlock goes to requester 1.
- Mid-operation reset: req2 read fires and rst drops in the next cycle -> rsp_valid = 0 that cycle; after release, state = IDLE and rr_ptr = 0.
- Stats (SRAM_ARB_STATS_EN): 5 fires by req3 -> stats_cnt[3] = 5; stats_clr pulsed coincident with a req3 fire -> 0.
